// File: rtl/gearbox_feed_arb.sv
// gearbox_feed_arb: arbitrates a 48-bit payload source and a 48-bit marker
// source into a single gearbox feed. Every MRK_PERIOD payload words it raises
// marker_due and admits a MRK_LEN-word marker burst. The marker may only start
// on a 48-bit gearbox boundary; once started, the burst owns the feed until it
// completes.
// Optional feature: define GBX_FEED_ARB_STATS_EN to build saturating grant and
// stall counters; otherwise the stat ports are tied to zero.
module gearbox_feed_arb #(
  parameter int unsigned MRK_PERIOD = 1024,
  parameter int unsigned MRK_LEN    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_enable,
  input  logic        a_req,
  input  logic [47:0] a_data,
  output logic        a_grant,
  input  logic        b_req,
  input  logic [47:0] b_data,
  output logic        b_grant,
  output logic        marker_due,
  input  logic        gb_out_idle,
  input  logic        gb_empty_save,
  output logic [47:0] gb_data,
  output logic        gb_datavalid,
  output logic [31:0] stat_a_cnt,
  output logic [31:0] stat_b_cnt,
  output logic [31:0] stat_stall_cnt
);

  typedef enum logic {S_PAY, S_MRK} state_t;

  localparam logic [2:0]  BURST_LEN = 3'(MRK_LEN);
  localparam logic [15:0] PCNT_LAST = 16'(MRK_PERIOD - 1);

  state_t      state_q, state_d;
  logic [2:0]  bcnt_q, bcnt_d;
  logic [15:0] pcnt_q, pcnt_d;
  logic        due_q, due_d;
  logic        ok;
  logic        burst_done;

  // reset_n is folded into ok so grants stay low during an asserted reset
  assign ok         = in_enable & gb_out_idle & reset_n;
  assign marker_due = due_q;

  // State, burst counter, period counter and marker request registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_PAY;
      bcnt_q  <= '0;
      pcnt_q  <= '0;
      due_q   <= 1'b0;
    end else if (in_enable) begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      pcnt_q  <= pcnt_d;
      due_q   <= due_d;
    end
  end

  // Grant arbitration and next-state logic
  always_comb begin
    a_grant    = 1'b0;
    b_grant    = 1'b0;
    burst_done = 1'b0;
    state_d    = state_q;
    bcnt_d     = bcnt_q;
    pcnt_d     = pcnt_q;
    due_d      = due_q;

    case (state_q)
      S_PAY: begin
        b_grant = ok & b_req & gb_empty_save;
        a_grant = ok & a_req & ~b_grant;
        if (b_grant) begin
          if (MRK_LEN > 1) begin
            state_d = S_MRK;
            bcnt_d  = 3'd1;
          end else begin
            burst_done = 1'b1;
          end
        end
      end
      S_MRK: begin
        b_grant = ok & b_req;
        if (b_grant) begin
          if (bcnt_q + 3'd1 == BURST_LEN) begin
            state_d    = S_PAY;
            bcnt_d     = '0;
            burst_done = 1'b1;
          end else begin
            bcnt_d = bcnt_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = S_PAY;
        bcnt_d  = '0;
      end
    endcase

    if (burst_done) begin
      due_d = 1'b0;
    end

    if (a_grant && !due_q) begin
      if (pcnt_q == PCNT_LAST) begin
        pcnt_d = '0;
        due_d  = 1'b1;
      end else begin
        pcnt_d = pcnt_q + 16'd1;
      end
    end
  end

  // Gearbox data mux
  always_comb begin
    gb_datavalid = a_grant | b_grant;
    if (b_grant) begin
      gb_data = b_data;
    end else if (a_grant) begin
      gb_data = a_data;
    end else begin
      gb_data = '0;
    end
  end

`ifdef GBX_FEED_ARB_STATS_EN
  logic [31:0] sa_q, sb_q, ss_q;
  logic        stall;

  assign stall = (a_req | b_req) & in_enable & ~(a_grant | b_grant);

  // Saturating statistics counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sa_q <= '0;
      sb_q <= '0;
      ss_q <= '0;
    end else if (in_enable) begin
      if (a_grant && sa_q != '1) sa_q <= sa_q + 32'd1;
      if (b_grant && sb_q != '1) sb_q <= sb_q + 32'd1;
      if (stall   && ss_q != '1) ss_q <= ss_q + 32'd1;
    end
  end

  assign stat_a_cnt     = sa_q;
  assign stat_b_cnt     = sb_q;
  assign stat_stall_cnt = ss_q;
`else
  assign stat_a_cnt     = '0;
  assign stat_b_cnt     = '0;
  assign stat_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_gearbox_feed_arb.sv
// Directed testbench for gearbox_feed_arb with MRK_PERIOD=4, MRK_LEN=2.
// Expected statistics depend on GBX_FEED_ARB_STATS_EN.
module tb_gearbox_feed_arb;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_enable;
  logic        a_req;
  logic [47:0] a_data;
  logic        a_grant;
  logic        b_req;
  logic [47:0] b_data;
  logic        b_grant;
  logic        marker_due;
  logic        gb_out_idle;
  logic        gb_empty_save;
  logic [47:0] gb_data;
  logic        gb_datavalid;
  logic [31:0] stat_a_cnt;
  logic [31:0] stat_b_cnt;
  logic [31:0] stat_stall_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  gearbox_feed_arb #(
    .MRK_PERIOD(4),
    .MRK_LEN   (2)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_enable     (in_enable),
    .a_req         (a_req),
    .a_data        (a_data),
    .a_grant       (a_grant),
    .b_req         (b_req),
    .b_data        (b_data),
    .b_grant       (b_grant),
    .marker_due    (marker_due),
    .gb_out_idle   (gb_out_idle),
    .gb_empty_save (gb_empty_save),
    .gb_data       (gb_data),
    .gb_datavalid  (gb_datavalid),
    .stat_a_cnt    (stat_a_cnt),
    .stat_b_cnt    (stat_b_cnt),
    .stat_stall_cnt(stat_stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the combinational grant outputs (0 none, 1 payload, 2 marker)
  task automatic chk_grant(input string tag, input int kind);
    #1;
    chk({tag, ".a_grant"}, 64'(a_grant), 64'(kind == 1));
    chk({tag, ".b_grant"}, 64'(b_grant), 64'(kind == 2));
    chk({tag, ".valid"}, 64'(gb_datavalid), 64'(kind != 0));
    chk({tag, ".data"}, 64'(gb_data),
        (kind == 1) ? 64'(a_data) : (kind == 2) ? 64'(b_data) : 64'd0);
  endtask

  logic [31:0] exp_sa, exp_sb, exp_ss;

  initial begin
    reset_n       = 1'b0;
    in_enable     = 1'b1;
    a_req         = 1'b1;
    b_req         = 1'b1;
    a_data        = 48'hA000_0000_0001;
    b_data        = 48'hB000_0000_0001;
    gb_out_idle   = 1'b1;
    gb_empty_save = 1'b1;

    // Reset state: grants suppressed even with both requests pending
    #3;
    chk_grant("reset", 0);
    chk("reset.marker_due", 64'(marker_due), 64'd0);
    tick();
    tick();
    reset_n = 1'b1;
    b_req   = 1'b0;

    // Four payload words raise marker_due on the following cycle
    for (int i = 0; i < 4; i++) begin
      a_data = 48'hA000_0000_0010 + 48'(i);
      chk_grant($sformatf("pay%0d", i), 1);
      chk($sformatf("pay%0d.due", i), 64'(marker_due), 64'd0);
      tick();
    end
    chk("period.due", 64'(marker_due), 64'd1);

    // First marker word on a boundary wins the tie with payload
    b_req  = 1'b1;
    b_data = 48'hB000_0000_0020;
    chk_grant("mrk0", 2);
    tick();

    // Inside the burst with no marker word: payload blocked for 5 cycles
    b_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk_grant($sformatf("mrkwait%0d", i), 0);
      tick();
    end
    chk("mrkwait.due", 64'(marker_due), 64'd1);

    // Second marker word needs no boundary inside the burst
    b_req         = 1'b1;
    gb_empty_save = 1'b0;
    b_data        = 48'hB000_0000_0021;
    chk_grant("mrk1", 2);
    tick();
    chk("burstend.due", 64'(marker_due), 64'd0);

    // Payload resumes (period count 1)
    b_req  = 1'b0;
    a_data = 48'hA000_0000_0030;
    chk_grant("resume", 1);
    tick();

    // Off-boundary tie goes to payload (period count 2)
    b_req  = 1'b1;
    a_data = 48'hA000_0000_0031;
    b_data = 48'hB000_0000_0031;
    chk_grant("tie_off", 1);
    tick();

    // On-boundary tie goes to marker, then finish the burst
    gb_empty_save = 1'b1;
    b_data        = 48'hB000_0000_0032;
    chk_grant("tie_on", 2);
    tick();
    b_data = 48'hB000_0000_0033;
    chk_grant("tie_on2", 2);
    tick();
    chk("tieburst.due", 64'(marker_due), 64'd0);

    // Gearbox busy: no grant
    gb_out_idle = 1'b0;
    chk_grant("busy", 0);
    tick();

    // Clock-enable low: no grant
    gb_out_idle = 1'b1;
    in_enable   = 1'b0;
    chk_grant("disabled", 0);
    tick();

    // Period count must still be 2: two more payload words raise marker_due
    in_enable = 1'b1;
    b_req     = 1'b0;
    a_data    = 48'hA000_0000_0040;
    chk_grant("pay_p2", 1);
    tick();
    chk("p3.due", 64'(marker_due), 64'd0);
    a_data = 48'hA000_0000_0041;
    chk_grant("pay_p3", 1);
    tick();
    chk("p4.due", 64'(marker_due), 64'd1);

    // Start a burst, then drop clock-enable mid-burst
    b_req  = 1'b1;
    b_data = 48'hB000_0000_0050;
    chk_grant("mrkA0", 2);
    tick();
    in_enable = 1'b0;
    tick();
    tick();
    in_enable = 1'b1;
    b_req     = 1'b0;
    chk_grant("held_mrk", 0);
    chk("held.due", 64'(marker_due), 64'd1);

    // Asynchronous reset mid-burst acts before the next edge
    b_req = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    chk_grant("rst_mid", 0);
    chk("rst_mid.due", 64'(marker_due), 64'd0);
    tick();
    reset_n       = 1'b1;
    gb_empty_save = 1'b0;
    a_data        = 48'hA000_0000_0060;
    chk_grant("post_rst_pay", 1);
    tick();
    gb_empty_save = 1'b1;
    b_data        = 48'hB000_0000_0060;
    chk_grant("post_rst_mrk", 2);
    tick();

    // Statistics: 10 payload grants, 2 marker grants, 3 stall cycles
    a_req   = 1'b0;
    b_req   = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    a_req   = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    a_req = 1'b0;
    b_req = 1'b1;
    tick();
    tick();
    b_req       = 1'b0;
    a_req       = 1'b1;
    gb_out_idle = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    a_req       = 1'b0;
    gb_out_idle = 1'b1;
    tick();
`ifdef GBX_FEED_ARB_STATS_EN
    exp_sa = 32'd10;
    exp_sb = 32'd2;
    exp_ss = 32'd3;
`else
    exp_sa = 32'd0;
    exp_sb = 32'd0;
    exp_ss = 32'd0;
`endif
    chk("stat_a", 64'(stat_a_cnt), 64'(exp_sa));
    chk("stat_b", 64'(stat_b_cnt), 64'(exp_sb));
    chk("stat_stall", 64'(stat_stall_cnt), 64'(exp_ss));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
